// File: rtl/mt9v034_embedded_sync_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : mt9v034_embedded_sync_serializer_if
// Brief    : Pixel stream handshake between a pixel source and the serializer.
// Revision : 1.0
// ============================================================================
interface mt9v034_embedded_sync_serializer_if;
    logic [9:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface
`default_nettype wire

// File: rtl/mt9v034_embedded_sync_serializer.sv
`default_nettype none
// ============================================================================
// Module   : mt9v034_embedded_sync_serializer
// Brief    : MT9V034-style LVDS transmit framer: embedded sync codes, 12-bit
//            words (start, 10 data LSB first, stop) serialized one bit/clock.
// Revision : 1.0
// ============================================================================
module mt9v034_embedded_sync_serializer #(
    parameter int         H_ACTIVE   = 752,
    parameter int         V_ACTIVE   = 480,
    parameter int         H_BLANK    = 94,
    parameter int         V_BLANK    = 45,
    parameter logic [9:0] FILL_PIXEL = 10'h001
) (
    input  wire logic                          TxClk,
    input  wire logic                          reset,
    input  wire logic                          enable,
    mt9v034_embedded_sync_serializer_if.slave  pix,
    output logic                               ser_out,
    output logic                               word_strobe,
    output logic                               frame_active,
    output logic                               underrun
);
    localparam int c_line_words = H_ACTIVE + H_BLANK + 6;
    localparam int c_pw         = $clog2(c_line_words);
    localparam int c_v_max      = (V_ACTIVE > V_BLANK) ? V_ACTIVE : V_BLANK;
    localparam int c_lw         = (c_v_max > 1) ? $clog2(c_v_max) : 1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SYNC_START = 3'd1,
        S_ACTIVE     = 3'd2,
        S_SYNC_END   = 3'd3,
        S_HBLANK     = 3'd4,
        S_VBLANK     = 3'd5
    } state_t;

    state_t            r_state;
    logic [3:0]        r_bit_cnt;
    logic [c_pw-1:0]   r_pix_cnt;
    logic [c_lw-1:0]   r_line_cnt;
    logic [11:0]       r_shift;
    logic              r_in_frame;
    logic              r_underrun;

    state_t            w_state_nxt;
    logic [c_pw-1:0]   w_pix_nxt;
    logic [c_lw-1:0]   w_line_nxt;
    logic [9:0]        w_word;
    logic [9:0]        w_clamped;
    logic              w_in_frame;
    logic              w_pix_slot;
    logic              w_word_end;
    logic              w_last_line;

    assign w_word_end  = (r_bit_cnt == 4'd11);
    assign w_last_line = (r_line_cnt == c_lw'(V_ACTIVE - 1));
    assign w_clamped   = (pix.s_data == 10'h3FF) ? 10'h3FE :
                         (pix.s_data == 10'h000) ? 10'h001 : pix.s_data;

    // Decides the word loaded at the end of the current word (bit 11).
    always_comb begin
        w_state_nxt = r_state;
        w_pix_nxt   = r_pix_cnt + 1'b1;
        w_line_nxt  = r_line_cnt;
        w_word      = 10'h000;
        w_in_frame  = 1'b0;
        w_pix_slot  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pix_nxt = '0;
                if (enable) begin
                    // FS word 0 leaves from IDLE directly; SYNC_START sends the rest.
                    w_word      = 10'h3FF;
                    w_in_frame  = 1'b1;
                    w_state_nxt = S_SYNC_START;
                    w_pix_nxt   = c_pw'(1);
                    w_line_nxt  = '0;
                end
            end
            S_SYNC_START: begin
                w_in_frame = 1'b1;
                case (r_pix_cnt)
                    c_pw'(0): w_word = 10'h3FF;
                    c_pw'(1): w_word = 10'h000;
                    default:  w_word = (r_line_cnt == '0) ? 10'h3FF : 10'h100;
                endcase
                if (r_pix_cnt == c_pw'(2)) begin
                    w_state_nxt = S_ACTIVE;
                    w_pix_nxt   = '0;
                end
            end
            S_ACTIVE: begin
                w_in_frame = 1'b1;
                w_pix_slot = 1'b1;
                w_word     = pix.s_valid ? w_clamped : FILL_PIXEL;
                if (r_pix_cnt == c_pw'(H_ACTIVE - 1)) begin
                    w_state_nxt = S_SYNC_END;
                    w_pix_nxt   = '0;
                end
            end
            S_SYNC_END: begin
                w_in_frame = 1'b1;
                case (r_pix_cnt)
                    c_pw'(0): w_word = 10'h3FF;
                    c_pw'(1): w_word = 10'h000;
                    default:  w_word = w_last_line ? 10'h300 : 10'h200;
                endcase
                if (r_pix_cnt == c_pw'(2)) begin
                    w_state_nxt = S_HBLANK;
                    w_pix_nxt   = '0;
                end
            end
            S_HBLANK: begin
                w_in_frame = !w_last_line;
                if (r_pix_cnt == c_pw'(H_BLANK - 1)) begin
                    w_pix_nxt = '0;
                    if (w_last_line) begin
                        w_state_nxt = S_VBLANK;
                        w_line_nxt  = '0;
                    end else begin
                        w_state_nxt = S_SYNC_START;
                        w_line_nxt  = r_line_cnt + 1'b1;
                    end
                end
            end
            S_VBLANK: begin
                if (r_pix_cnt == c_pw'(c_line_words - 1)) begin
                    w_pix_nxt = '0;
                    if (r_line_cnt == c_lw'(V_BLANK - 1)) begin
                        w_line_nxt  = '0;
                        w_state_nxt = enable ? S_SYNC_START : S_IDLE;
                    end else begin
                        w_line_nxt = r_line_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_pix_nxt   = '0;
                w_line_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge TxClk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 4'd0;
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
            r_shift    <= 12'h001;
            r_in_frame <= 1'b0;
            r_underrun <= 1'b0;
        end else if (w_word_end) begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= 4'd0;
            r_pix_cnt  <= w_pix_nxt;
            r_line_cnt <= w_line_nxt;
            r_shift    <= {1'b0, w_word, 1'b1};
            r_in_frame <= w_in_frame;
            if (w_pix_slot && !pix.s_valid) begin
                r_underrun <= 1'b1;
            end
        end else begin
            r_bit_cnt  <= r_bit_cnt + 4'd1;
            r_shift    <= {1'b0, r_shift[11:1]};
        end
    end

    // Outputs are forced low while reset is held, independent of the word in flight.
    assign pix.s_ready  = !reset && w_word_end && w_pix_slot;
    assign ser_out      = !reset && r_shift[0];
    assign word_strobe  = !reset && (r_bit_cnt == 4'd0);
    assign frame_active = r_in_frame;
    assign underrun     = r_underrun;
endmodule
`default_nettype wire

// File: tb/tb_mt9v034_embedded_sync_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mt9v034_embedded_sync_serializer
// Brief    : Random + directed bench against a frame-queue reference model.
// Revision : 1.0
// ============================================================================
module tb_mt9v034_embedded_sync_serializer;
    localparam int         c_ha   = 4;
    localparam int         c_va   = 2;
    localparam int         c_hb   = 2;
    localparam int         c_vb   = 1;
    localparam logic [9:0] c_fill = 10'h001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic ser_out, word_strobe, frame_active, underrun;

    mt9v034_embedded_sync_serializer_if pix();

    mt9v034_embedded_sync_serializer #(
        .H_ACTIVE(c_ha), .V_ACTIVE(c_va), .H_BLANK(c_hb), .V_BLANK(c_vb), .FILL_PIXEL(c_fill)
    ) u_dut (
        .TxClk(clk), .reset(rst), .enable(en), .pix(pix),
        .ser_out(ser_out), .word_strobe(word_strobe),
        .frame_active(frame_active), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] w;
        bit         is_pix;
        bit         infr;
        bit         vlast;
    } slot_t;

    // Reference model: the wire as a queue of whole words built per frame.
    slot_t      m_q[$];
    int         m_bit     = 0;
    logic [9:0] m_word    = '0;
    bit         m_infr    = 0;
    bit         m_under   = 0;
    bit         m_pend    = 0;
    bit         m_cur_pix = 0;

    int         n_total = 0;
    int         n_bad   = 0;
    bit         rx_on   = 0;
    logic [9:0] rx_acc  = '0;
    logic [9:0] rx_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] clamp(input logic [9:0] d);
        if (d == 10'h3FF) return 10'h3FE;
        if (d == 10'h000) return 10'h001;
        return d;
    endfunction

    task automatic push(input logic [9:0] w, input bit p, input bit f, input bit v);
        slot_t s;
        s.w = w; s.is_pix = p; s.infr = f; s.vlast = v;
        m_q.push_back(s);
    endtask

    task automatic push_frame();
        int nvb;
        nvb = c_vb * (c_ha + c_hb + 6);
        for (int l = 0; l < c_va; l++) begin
            push(10'h3FF, 0, 1, 0);
            push(10'h000, 0, 1, 0);
            push((l == 0) ? 10'h3FF : 10'h100, 0, 1, 0);
            for (int p = 0; p < c_ha; p++) push(10'h000, 1, 1, 0);
            push(10'h3FF, 0, 1, 0);
            push(10'h000, 0, 1, 0);
            push((l == c_va - 1) ? 10'h300 : 10'h200, 0, 1, 0);
            for (int h = 0; h < c_hb; h++) push(10'h000, 0, (l != c_va - 1), 0);
        end
        for (int n = 0; n < nvb; n++) push(10'h000, 0, 0, (n == nvb - 1));
    endtask

    task automatic model_step(output bit took);
        slot_t s;
        took = 0;
        if (rst) begin
            m_bit = 0; m_word = '0; m_infr = 0; m_under = 0;
            m_pend = 0; m_cur_pix = 0; m_q.delete();
        end else if (m_bit == 11) begin
            if (m_q.size() == 0 && (m_pend || en)) begin
                push_frame();
                m_pend = 0;
            end
            if (m_q.size() != 0) begin
                s = m_q.pop_front();
                m_infr = s.infr;
                m_cur_pix = s.is_pix;
                if (s.is_pix) begin
                    if (pix.s_valid) begin
                        m_word = clamp(pix.s_data);
                        took = 1;
                    end else begin
                        m_word = c_fill;
                        m_under = 1;
                    end
                end else begin
                    m_word = s.w;
                end
                if (s.vlast) m_pend = en;
            end else begin
                m_word = '0; m_infr = 0; m_cur_pix = 0;
            end
            m_bit = 0;
        end else begin
            m_bit++;
        end
    endtask

    // One clock: check the cycle in progress, then apply new inputs for the next edge.
    task automatic tick(input bit nrst, input bit nen, input bit nsv, input logic [9:0] nsd,
                        input bit do_chk, output bit took);
        bit exp_bit, exp_rdy;
        @(negedge clk);
        if (do_chk) begin
            exp_bit = (m_bit == 0) ? 1'b1 : (m_bit == 11) ? 1'b0 : m_word[m_bit-1];
            exp_rdy = (m_bit == 11) && (m_q.size() != 0) && m_q[0].is_pix;
            chk("ser_out",      {31'd0, ser_out},          {31'd0, exp_bit && !rst});
            chk("word_strobe",  {31'd0, word_strobe},      {31'd0, (m_bit == 0) && !rst});
            chk("s_ready",      {31'd0, pix.s_ready},      {31'd0, exp_rdy && !rst});
            chk("frame_active", {31'd0, frame_active},     {31'd0, m_infr});
            chk("underrun",     {31'd0, underrun},         {31'd0, m_under});
            if (rx_on && !rst) begin
                if (m_bit >= 1 && m_bit <= 10) rx_acc[m_bit-1] = ser_out;
                if (m_bit == 11) rx_q.push_back(rx_acc);
            end
        end
        rst = nrst; en = nen; pix.s_valid = nsv; pix.s_data = nsd;
        model_step(took);
    endtask

    initial begin
        logic [9:0] dir_data[8];
        logic [9:0] exp_rx[38];
        logic [9:0] sd;
        int         k;
        int         w_i;
        bit         took;
        bit         found;

        for (int i = 0; i < 8; i++) dir_data[i] = 10'((i + 1) * 16);
        w_i = 0;
        exp_rx[w_i++] = 10'h000;
        for (int l = 0; l < 2; l++) begin
            exp_rx[w_i++] = 10'h3FF; exp_rx[w_i++] = 10'h000;
            exp_rx[w_i++] = (l == 0) ? 10'h3FF : 10'h100;
            for (int p = 0; p < 4; p++) exp_rx[w_i++] = dir_data[l*4+p];
            exp_rx[w_i++] = 10'h3FF; exp_rx[w_i++] = 10'h000;
            exp_rx[w_i++] = (l == 0) ? 10'h200 : 10'h300;
            if (l == 0) begin exp_rx[w_i++] = 10'h000; exp_rx[w_i++] = 10'h000; end
        end
        for (int z = 0; z < 14; z++) exp_rx[w_i++] = 10'h000;
        exp_rx[w_i++] = 10'h3FF;

        pix.s_valid = 1'b0;
        pix.s_data  = '0;
        for (int i = 0; i < 3; i++) tick(1, 1, 1, dir_data[0], 0, took);

        // Directed frame: known pixel ramp, always valid.
        rx_on = 1;
        k = 0;
        for (int i = 0; i < 41 * 12; i++) begin
            tick(0, 1, 1, dir_data[(k > 7) ? 7 : k], 1, took);
            if (took) k++;
        end
        rx_on = 0;
        chk("rx_count", {31'd0, rx_q.size() >= 38}, 32'd1);
        for (int i = 0; i < 38; i++)
            if (i < rx_q.size()) chk($sformatf("rx_word%0d", i), {22'd0, rx_q[i]}, {22'd0, exp_rx[i]});

        // Random traffic with clamp-biased data, sporadic underruns and enable toggles.
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(3))
                0:       sd = 10'h3FF;
                1:       sd = 10'h000;
                default: sd = 10'($urandom);
            endcase
            tick(0, ($urandom_range(299) == 0) ? !en : en, ($urandom_range(5) != 0), sd, 1, took);
        end

        // Reset in the middle of a pixel word.
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            if (m_cur_pix && m_bit == 5 && !rst) found = 1;
            tick(found, 1, ($urandom_range(5) != 0), 10'($urandom), 1, took);
        end
        chk("rst_mid_word_reached", {31'd0, found}, 32'd1);
        tick(1, 0, 1, 10'h055, 1, took);
        for (int i = 0; i < 100; i++) tick(0, 0, 1, 10'h055, 1, took);

        // Enable dropped right after FS: frame must still complete, then idle.
        for (int i = 0; i < 40; i++) tick(0, 1, 1, 10'($urandom), 1, took);
        for (int i = 0; i < 700; i++) tick(0, 0, ($urandom_range(3) != 0), 10'($urandom), 1, took);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
